// File: rtl/timer_16bit_countdown.sv
// timer_16bit_countdown: loadable 16-bit down-counting timer with IDLE/RUN
// sequencing, one-shot or auto-reload operation and a single-cycle expiry pulse.
// Optional prescaler enabled by defining TIMER_CD_PRESCALE_EN (adds the
// PS_WIDTH parameter and the prescale port).
module timer_16bit_countdown #(
  parameter int WIDTH = 16
`ifdef TIMER_CD_PRESCALE_EN
  , parameter int PS_WIDTH = 8
`endif
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic                stop,
  input  logic                pause,
  input  logic                auto_reload,
  input  logic [WIDTH-1:0]    load_value,
`ifdef TIMER_CD_PRESCALE_EN
  input  logic [PS_WIDTH-1:0] prescale,
`endif
  output logic                busy,
  output logic                timer_done,
  output logic [WIDTH-1:0]    count
);

  // One-hot style encoding so that the two illegal codes fall into default.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b01,
    ST_RUN  = 2'b10
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             tick_s;
  logic             cnt_zero_s;

  assign cnt_zero_s = (count_q == {WIDTH{1'b0}});

`ifdef TIMER_CD_PRESCALE_EN
  logic [PS_WIDTH-1:0] ps_q, ps_d;

  // Prescaler: divides RUN cycles into ticks; frozen by pause, cleared on start/stop/tick.
  always_comb begin
    tick_s = 1'b0;
    ps_d   = ps_q;
    if (stop || start) begin
      ps_d = {PS_WIDTH{1'b0}};
    end else if ((state_q == ST_RUN) && !pause) begin
      // >= rather than == so a prescale lowered mid-run cannot force a long wrap.
      if (ps_q >= prescale) begin
        tick_s = 1'b1;
        ps_d   = {PS_WIDTH{1'b0}};
      end else begin
        ps_d = ps_q + {{(PS_WIDTH-1){1'b0}}, 1'b1};
      end
    end else begin
      ps_d = ps_q;
    end
  end

  // Prescaler register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ps_q <= {PS_WIDTH{1'b0}};
    end else begin
      ps_q <= ps_d;
    end
  end
`else
  // Without a prescaler every unpaused cycle is a tick.
  always_comb begin
    tick_s = ~pause;
  end
`endif

  // FSM state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: stop beats start, start beats expiry.
  always_comb begin
    state_d = ST_IDLE;
    case (state_q)
      ST_IDLE: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (start) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (start) begin
          state_d = ST_RUN;
        end else if (tick_s && cnt_zero_s && !auto_reload) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Datapath and outputs: count/reload updates and the expiry pulse.
  always_comb begin
    count_d  = count_q;
    reload_d = reload_q;
    done_d   = 1'b0;
    if (stop) begin
      count_d = {WIDTH{1'b0}};
    end else if (start) begin
      count_d  = load_value;
      reload_d = load_value;
    end else if ((state_q == ST_RUN) && tick_s) begin
      if (!cnt_zero_s) begin
        count_d = count_q - {{(WIDTH-1){1'b0}}, 1'b1};
      end else begin
        // Expiry: zero is never decremented, so the counter cannot wrap.
        done_d = 1'b1;
        if (auto_reload) begin
          count_d = reload_q;
        end else begin
          count_d = count_q;
        end
      end
    end else begin
      count_d = count_q;
    end
    busy_d = (state_d == ST_RUN);
  end

  // Datapath and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q  <= {WIDTH{1'b0}};
      reload_q <= {WIDTH{1'b0}};
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      count_q  <= count_d;
      reload_q <= reload_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign busy       = busy_q;
  assign timer_done = done_q;
  assign count      = count_q;

endmodule

// File: tb/tb_timer_16bit_countdown.sv
// Self-checking bench for timer_16bit_countdown: directed scenarios plus
// randomized stimulus against a behavioural reference model.
module tb_timer_16bit_countdown;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        pause = 1'b0;
  logic        auto_reload = 1'b0;
  logic [15:0] load_value = 16'h0000;
  logic        busy;
  logic        timer_done;
  logic [15:0] count;
`ifdef TIMER_CD_PRESCALE_EN
  logic [7:0]  prescale = 8'h00;
`endif

  timer_16bit_countdown dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .stop        (stop),
    .pause       (pause),
    .auto_reload (auto_reload),
    .load_value  (load_value),
`ifdef TIMER_CD_PRESCALE_EN
    .prescale    (prescale),
`endif
    .busy        (busy),
    .timer_done  (timer_done),
    .count       (count)
  );

  always #5 clock = ~clock;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc_n    = 0;

  // Reference model state
  bit m_run;
  int m_count;
  int m_reload;
  bit m_done;
  int m_ps;

  task automatic chk(input string tag, input int got, input int exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 1'b0; m_count = 0; m_reload = 0; m_done = 1'b0; m_ps = 0;
  endtask

  // One clock edge of the behavioural timer, using the inputs seen at that edge.
  task automatic model_step();
    bit tick;
    int pdiv;
    pdiv = 0;
`ifdef TIMER_CD_PRESCALE_EN
    pdiv = int'(prescale);
`endif
    m_done = 1'b0;
    if (reset) begin
      model_reset();
    end else if (stop) begin
      m_run = 1'b0; m_count = 0; m_ps = 0;
    end else if (start) begin
      m_run = 1'b1; m_count = int'(load_value); m_reload = m_count; m_ps = 0;
    end else if (m_run && !pause) begin
      tick = (m_ps >= pdiv);
      m_ps = tick ? 0 : m_ps + 1;
      if (tick) begin
        if (m_count > 0) m_count = m_count - 1;
        else begin
          m_done = 1'b1;
          if (auto_reload) m_count = m_reload;
          else m_run = 1'b0;
        end
      end
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    cyc_n++;
    model_step();
    #1;
    chk("busy", 32'(busy), 32'(m_run));
    chk("timer_done", 32'(timer_done), 32'(m_done));
    chk("count", 32'(count), m_count);
  endtask

  task automatic pulse_start(input logic [15:0] n);
    load_value = n;
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  initial begin
    int e0;
    int pulses;
    int done_at;
    int guard;
    model_reset();

    // Reset state
    #2;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(timer_done), 0);
    chk("rst_count", 32'(count), 0);
    cyc();
    cyc();
    reset = 1'b0;
    cyc();

    // Reset in the middle of a run
    pulse_start(16'd100);
    repeat (10) cyc();
    chk("midrun_count", 32'(count), 90);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    chk("arst_busy", 32'(busy), 0);
    chk("arst_count", 32'(count), 0);
    chk("arst_done", 32'(timer_done), 0);
    cyc();
    reset = 1'b0;
    cyc();

    // One-shot N=3
    pulse_start(16'd3);
    e0 = cyc_n; pulses = 0; done_at = -1;
    repeat (25) begin
      cyc();
      if (timer_done) begin pulses++; done_at = cyc_n - e0; end
    end
    chk("oneshot_pulses", pulses, 1);
    chk("oneshot_done_edge", done_at, 4);

    // Auto-reload N=2
    auto_reload = 1'b1;
    pulse_start(16'd2);
    pulses = 0;
    repeat (12) begin
      cyc();
      if (timer_done) pulses++;
    end
    chk("autoreload_pulses", pulses, 4);
    auto_reload = 1'b0;
    pulses = 0; guard = 0;
    while (busy && guard < 10) begin
      cyc(); guard++;
      if (timer_done) pulses++;
    end
    chk("autoreload_drop_idle", 32'(busy), 0);
    chk("autoreload_drop_pulses", pulses, 1);

    // Pause for 4 cycles at count 3, N=5
    pulse_start(16'd5);
    e0 = cyc_n; guard = 0;
    while (count != 16'd3 && guard < 20) begin cyc(); guard++; end
    chk("pause_reach3", 32'(count), 3);
    pause = 1'b1;
    repeat (4) begin
      cyc();
      chk("pause_hold", 32'(count), 3);
    end
    pause = 1'b0;
    done_at = -1; guard = 0;
    while (done_at < 0 && guard < 30) begin
      cyc(); guard++;
      if (timer_done) done_at = cyc_n - e0;
    end
    chk("pause_done_edge", done_at, 10);

    // Stop on the same edge as an expiry
    pulse_start(16'd0);
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    chk("stop_exp_done", 32'(timer_done), 0);
    chk("stop_exp_busy", 32'(busy), 0);

    // Start on the same edge as an expiry
    pulse_start(16'd0);
    pulse_start(16'd7);
    chk("start_exp_done", 32'(timer_done), 0);
    chk("start_exp_count", 32'(count), 7);
    stop = 1'b1;
    cyc();
    stop = 1'b0;

`ifdef TIMER_CD_PRESCALE_EN
    // Prescale 3, N=1 -> expiry 8 edges after start
    prescale = 8'd3;
    pulse_start(16'd1);
    e0 = cyc_n; done_at = -1;
    repeat (20) begin
      cyc();
      if (timer_done) done_at = cyc_n - e0;
    end
    chk("prescale_done_edge", done_at, 8);
    prescale = 8'd0;
`endif

    // Randomized traffic
    repeat (400) begin
      start       = ($urandom_range(0, 11) == 0);
      stop        = ($urandom_range(0, 29) == 0);
      pause       = ($urandom_range(0, 4) == 0);
      auto_reload = $urandom_range(0, 1) == 1;
      load_value  = 16'($urandom_range(0, 6));
      cyc();
    end
    start = 1'b0; stop = 1'b1; pause = 1'b0; auto_reload = 1'b0;
    cyc();
    stop = 1'b0;

    // Full-range one-shot: must end at 0 without underflow
    pulse_start(16'hFFFF);
    pulses = 0; guard = 0;
    while (busy && guard < 70000) begin
      cyc(); guard++;
      if (timer_done) pulses++;
    end
    chk("full_idle", 32'(busy), 0);
    chk("full_count", 32'(count), 0);
    chk("full_pulses", pulses, 1);
    repeat (3) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
